// File: rtl/paint_pkg.sv
// Shared types and default widths for the circle-painter arbiter and its requesters.
package paint_pkg;

  localparam int unsigned DEF_HCOUNT_W = 11;
  localparam int unsigned DEF_VCOUNT_W = 10;
  localparam int unsigned DEF_RADIUS_W = 17;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

  typedef struct packed {
    logic [DEF_HCOUNT_W-1:0] hcount;
    logic [DEF_VCOUNT_W-1:0] vcount;
    logic [DEF_RADIUS_W-1:0] radius;
  } paint_job_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester above last_grant, wrapping, wins.
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxW = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   last_grant,
  output logic [NumReq-1:0] grant,
  output logic [IdxW-1:0]   grant_idx
);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      cand = IdxW'((32'(last_grant) + k) % NumReq);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/paint_arbiter.sv
// Round-robin scheduler sharing one circle painter among NUM_REQ draw requesters.
// Define PAINT_ARBITER_STATS_EN to add issued/dropped/clamped job counters.
module paint_arbiter
  import paint_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned HCOUNT_W   = DEF_HCOUNT_W,
  parameter int unsigned VCOUNT_W   = DEF_VCOUNT_W,
  parameter int unsigned RADIUS_W   = DEF_RADIUS_W,
  parameter int unsigned MAX_RADIUS = 64,
  localparam int unsigned IdW = $clog2(NUM_REQ)
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic [NUM_REQ-1:0]           req_valid_in,
  input  logic [NUM_REQ*HCOUNT_W-1:0]  req_hcount_in,
  input  logic [NUM_REQ*VCOUNT_W-1:0]  req_vcount_in,
  input  logic [NUM_REQ*RADIUS_W-1:0]  req_radius_in,
  output logic [NUM_REQ-1:0]           req_ready_out,
  input  logic                         hold_in,
  input  logic                         painter_ready_in,
  output logic                         painter_valid_out,
  output logic [HCOUNT_W-1:0]          painter_hcount_out,
  output logic [VCOUNT_W-1:0]          painter_vcount_out,
  output logic [RADIUS_W-1:0]          painter_radius_out,
  output logic [IdW-1:0]               grant_id_out,
  output logic                         busy_out
`ifdef PAINT_ARBITER_STATS_EN
  ,
  output logic [15:0]                  jobs_issued_out,
  output logic [15:0]                  jobs_dropped_out,
  output logic [15:0]                  jobs_clamped_out
`endif
);

  arb_state_t          state_q, state_d;
  logic [IdW-1:0]      last_grant_q;
  logic [NUM_REQ-1:0]  win_onehot;
  logic [IdW-1:0]      win_idx;
  logic                accept, drop, clamp;
  logic [HCOUNT_W-1:0] sel_hcount;
  logic [VCOUNT_W-1:0] sel_vcount;
  logic [RADIUS_W-1:0] sel_radius;

  rr_arbiter #(
    .NumReq(NUM_REQ)
  ) u_rr_arbiter (
    .req       (req_valid_in),
    .last_grant(last_grant_q),
    .grant     (win_onehot),
    .grant_idx (win_idx)
  );

  assign accept        = (state_q == IDLE) && !hold_in && painter_ready_in && (|req_valid_in);
  assign req_ready_out = accept ? win_onehot : '0;

  always_comb begin
    sel_hcount = '0;
    sel_vcount = '0;
    sel_radius = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IdW'(i)) begin
        sel_hcount = req_hcount_in[i*HCOUNT_W +: HCOUNT_W];
        sel_vcount = req_vcount_in[i*VCOUNT_W +: VCOUNT_W];
        sel_radius = req_radius_in[i*RADIUS_W +: RADIUS_W];
      end
    end
  end

  assign drop  = (sel_radius == '0);
  assign clamp = (sel_radius > RADIUS_W'(MAX_RADIUS));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept && !drop) state_d = ISSUE;
      ISSUE:     state_d = WAIT_BUSY;
      // The painter drops ready at least one cycle per job, so wait for that first.
      WAIT_BUSY: if (!painter_ready_in) state_d = WAIT_DONE;
      WAIT_DONE: if (painter_ready_in) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q            <= IDLE;
      last_grant_q       <= IdW'(NUM_REQ - 1);
      painter_hcount_out <= '0;
      painter_vcount_out <= '0;
      painter_radius_out <= '0;
      grant_id_out       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= win_idx;
        // Zero-radius jobs are consumed without disturbing the in-flight payload.
        if (!drop) begin
          painter_hcount_out <= sel_hcount;
          painter_vcount_out <= sel_vcount;
          painter_radius_out <= clamp ? RADIUS_W'(MAX_RADIUS) : sel_radius;
          grant_id_out       <= win_idx;
        end
      end
    end
  end

  assign painter_valid_out = (state_q == ISSUE);
  assign busy_out          = (state_q != IDLE);

`ifdef PAINT_ARBITER_STATS_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      jobs_issued_out  <= '0;
      jobs_dropped_out <= '0;
      jobs_clamped_out <= '0;
    end else begin
      if (state_q == ISSUE) jobs_issued_out <= jobs_issued_out + 16'd1;
      if (accept && drop) jobs_dropped_out <= jobs_dropped_out + 16'd1;
      if (accept && !drop && clamp) jobs_clamped_out <= jobs_clamped_out + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_paint_arbiter.sv
// Bench for paint_arbiter: vector table, directed corner sequences, and random traffic
// checked by a cycle-level reference model with a simple painter model.
`timescale 1ns/1ps
module tb_paint_arbiter;
  import paint_pkg::*;

  localparam int N    = 4;
  localparam int HW   = 11;
  localparam int VW   = 10;
  localparam int RW   = 17;
  localparam int MAXR = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*HW-1:0]   req_h;
  logic [N*VW-1:0]   req_v;
  logic [N*RW-1:0]   req_r;
  logic [N-1:0]      req_ready;
  logic              hold;
  logic              pm_ready;
  logic              prdy_en;
  logic              painter_ready;
  logic              pv;
  logic [HW-1:0]     ph;
  logic [VW-1:0]     pvv;
  logic [RW-1:0]     pr;
  logic [1:0]        gid;
  logic              busy;
`ifdef PAINT_ARBITER_STATS_EN
  logic [15:0]       st_issued, st_dropped, st_clamped;
`endif

  paint_job_t job [N];

  always #5 clk = ~clk;
  assign painter_ready = pm_ready & prdy_en;

  always_comb begin
    req_h = '0;
    req_v = '0;
    req_r = '0;
    for (int i = 0; i < N; i++) begin
      req_h[i*HW +: HW] = job[i].hcount;
      req_v[i*VW +: VW] = job[i].vcount;
      req_r[i*RW +: RW] = job[i].radius;
    end
  end

  paint_arbiter dut (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
    .req_valid_in      (req_valid),
    .req_hcount_in     (req_h),
    .req_vcount_in     (req_v),
    .req_radius_in     (req_r),
    .req_ready_out     (req_ready),
    .hold_in           (hold),
    .painter_ready_in  (painter_ready),
    .painter_valid_out (pv),
    .painter_hcount_out(ph),
    .painter_vcount_out(pvv),
    .painter_radius_out(pr),
    .grant_id_out      (gid),
    .busy_out          (busy)
`ifdef PAINT_ARBITER_STATS_EN
    ,
    .jobs_issued_out   (st_issued),
    .jobs_dropped_out  (st_dropped),
    .jobs_clamped_out  (st_clamped)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic paint_job_t mkjob(input int h, input int v, input int r);
    paint_job_t j;
    j.hcount = h[HW-1:0];
    j.vcount = v[VW-1:0];
    j.radius = r[RW-1:0];
    return j;
  endfunction

  // Painter model: after seeing a strobe it holds ready low for busy_cycles cycles.
  int   busy_cycles = 5;
  int   pm_cnt      = 0;
  logic pm_start;
  initial begin
    pm_ready = 1'b1;
    forever begin
      @(negedge clk);
      pm_start = pv;
      @(posedge clk);
      #1;
      if (!rst_n) pm_cnt = 0;
      else if (pm_start) pm_cnt = busy_cycles;
      else if (pm_cnt > 0) pm_cnt--;
      pm_ready = (pm_cnt == 0);
    end
  end

  // Reference model: rotating priority pointer, one job in flight at a time.
  bit         sb_en = 1'b0;
  int         m_ptr;
  bit         m_inflight, m_seen_low, m_exp_strobe;
  paint_job_t m_job;
  int         m_job_id;
  int         m_issued, m_dropped, m_clamped;
  int         grant_log[$];

  task automatic sb_init();
    m_ptr = N - 1;
    m_inflight = 0;
    m_seen_low = 0;
    m_exp_strobe = 0;
    m_issued = 0;
    m_dropped = 0;
    m_clamped = 0;
  endtask

  task automatic sb_step();
    logic [N-1:0] exp_rdy;
    int           win;
    int           idx;
    paint_job_t   j;
    exp_rdy = '0;
    win = -1;
    check("strobe", 32'(pv), 32'(m_exp_strobe));
    check("busy", 32'(busy), 32'(m_inflight));
    if (pv) grant_log.push_back(int'(gid));
    if (m_exp_strobe) begin
      check("strobe_id", 32'(gid), m_job_id);
      check("strobe_h", 32'(ph), 32'(m_job.hcount));
      check("strobe_v", 32'(pvv), 32'(m_job.vcount));
      check("strobe_r", 32'(pr), 32'(m_job.radius));
      m_issued++;
    end
`ifdef PAINT_ARBITER_STATS_EN
    check("stat_issued", 32'(st_issued), (m_issued - (m_exp_strobe ? 1 : 0)) & 16'hFFFF);
    check("stat_dropped", 32'(st_dropped), m_dropped & 16'hFFFF);
    check("stat_clamped", 32'(st_clamped), m_clamped & 16'hFFFF);
`endif
    if (!m_inflight && !hold && painter_ready) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_ptr + k) % N;
        if (win < 0 && ((req_valid >> idx) & 1) != 0) win = idx;
      end
    end
    if (win >= 0) exp_rdy = N'(1) << win;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (m_inflight && !m_exp_strobe) begin
      if (!painter_ready) m_seen_low = 1;
      else if (m_seen_low) m_inflight = 0;
    end
    m_exp_strobe = 0;
    if (win >= 0) begin
      m_ptr = win;
      j = job[win];
      if (j.radius == 0) begin
        m_dropped++;
      end else begin
        if (j.radius > MAXR) begin
          j.radius = RW'(MAXR);
          m_clamped++;
        end
        m_inflight = 1;
        m_seen_low = 0;
        m_exp_strobe = 1;
        m_job = j;
        m_job_id = win;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb_en) sb_step();
    end
  end

  task automatic do_reset();
    sb_en = 0;
    req_valid = '0;
    hold = 1'b0;
    prdy_en = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    sb_init();
    grant_log.delete();
    sb_en = 1;
  endtask

  // Call at a drive point; returns at the drive point of the cycle after the accept.
  task automatic send(input int id, input int h, input int v, input int r);
    bit ok;
    ok = 0;
    job[id] = mkjob(h, v, r);
    req_valid[id] = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
    check("send_accept", 32'(ok), 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!busy && painter_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    check("idle_timeout", 32'(ok), 1);
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic         hold;
    logic         prdy;
    logic [N-1:0] exp_ready;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] acc;
    int           sel;
    int           exp_order [5];
    rst_n = 1'b0;
    req_valid = '0;
    hold = 1'b0;
    prdy_en = 1'b1;
    for (int i = 0; i < N; i++) job[i] = mkjob(0, 0, 0);
    sb_init();

    // Reset state
    #23;
    check("rst_ready", 32'(req_ready), 0);
    check("rst_valid", 32'(pv), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_h", 32'(ph), 0);
    check("rst_r", 32'(pr), 0);
    check("rst_gid", 32'(gid), 0);

    // First job: accept in cycle 0, strobe with payload in cycle 1
    do_reset();
    job[0] = mkjob(320, 240, 10);
    req_valid = 4'b0001;
    @(negedge clk);
    check("t1_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("t1_strobe", 32'(pv), 1);
    check("t1_h", 32'(ph), 320);
    check("t1_v", 32'(pvv), 240);
    check("t1_r", 32'(pr), 10);
    check("t1_busy", 32'(busy), 1);
    @(posedge clk);
    #1 wait_idle();

    // Arbitration table with zero-radius jobs, so the FSM stays idle each row
    tbl[0]  = '{4'b0000, 1'b0, 1'b1, 4'b0000};
    tbl[1]  = '{4'b1111, 1'b1, 1'b1, 4'b0000};
    tbl[2]  = '{4'b1111, 1'b0, 1'b1, 4'b0001};
    tbl[3]  = '{4'b1111, 1'b0, 1'b1, 4'b0010};
    tbl[4]  = '{4'b1001, 1'b0, 1'b1, 4'b1000};
    tbl[5]  = '{4'b0110, 1'b0, 1'b1, 4'b0010};
    tbl[6]  = '{4'b0010, 1'b0, 1'b1, 4'b0010};
    tbl[7]  = '{4'b0001, 1'b0, 1'b1, 4'b0001};
    tbl[8]  = '{4'b1100, 1'b0, 1'b1, 4'b0100};
    tbl[9]  = '{4'b0011, 1'b1, 1'b1, 4'b0000};
    tbl[10] = '{4'b0011, 1'b0, 1'b1, 4'b0001};
    tbl[11] = '{4'b1110, 1'b0, 1'b1, 4'b0010};
    tbl[12] = '{4'b1111, 1'b0, 1'b0, 4'b0000};
    tbl[13] = '{4'b1111, 1'b0, 1'b1, 4'b0100};
    do_reset();
    for (int i = 0; i < N; i++) job[i] = mkjob(i, i, 0);
    for (int i = 0; i < 14; i++) begin
      req_valid = tbl[i].valid;
      hold = tbl[i].hold;
      prdy_en = tbl[i].prdy;
      @(negedge clk);
      check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
      check($sformatf("vec%0d_nostrobe", i), 32'(pv), 0);
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    hold = 1'b0;
    prdy_en = 1'b1;
`ifdef PAINT_ARBITER_STATS_EN
    @(negedge clk);
    check("vec_dropped", 32'(st_dropped), 10);
    @(posedge clk);
    #1;
`endif

    // All four requesting continuously, 5-cycle painter
    do_reset();
    busy_cycles = 5;
    for (int i = 0; i < N; i++) job[i] = mkjob(100 + i, 50 + i, 7);
    req_valid = 4'b1111;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (grant_log.size() >= 5) break;
    end
    @(posedge clk);
    #1 req_valid = '0;
    exp_order = '{0, 1, 2, 3, 0};
    check("t2_count", 32'(grant_log.size()), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check($sformatf("t2_order%0d", i), 32'(grant_log[i]), 32'(exp_order[i]));
    wait_idle();

    // Oversized radius is clamped
    do_reset();
    send(2, 100, 50, 200);
    @(negedge clk);
    check("t3_strobe", 32'(pv), 1);
    check("t3_r", 32'(pr), MAXR);
    check("t3_gid", 32'(gid), 2);
`ifdef PAINT_ARBITER_STATS_EN
    check("t3_clamped", 32'(st_clamped), 1);
`endif
    @(posedge clk);
    #1 wait_idle();

    // Zero radius: accepted, dropped, next grant to requester 2
    do_reset();
    job[1] = mkjob(5, 6, 0);
    job[2] = mkjob(11, 22, 5);
    req_valid = 4'b0110;
    @(negedge clk);
    check("t4_ready1", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    check("t4_nostrobe", 32'(pv), 0);
    check("t4_ready2", 32'(req_ready), 32'h4);
`ifdef PAINT_ARBITER_STATS_EN
    check("t4_dropped", 32'(st_dropped), 1);
`endif
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    @(negedge clk);
    check("t4_strobe", 32'(pv), 1);
    check("t4_gid", 32'(gid), 2);
    check("t4_r", 32'(pr), 5);
    @(posedge clk);
    #1 wait_idle();

    // hold_in during an in-flight job
    do_reset();
    busy_cycles = 4;
    send(0, 1, 2, 9);
    hold = 1'b1;
    for (int i = 1; i < N; i++) job[i] = mkjob(i, i, 3);
    req_valid = 4'b1110;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      check("t5_hold_ready", 32'(req_ready), 0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("t5_done", 32'(busy), 0);
    @(posedge clk);
    #1 hold = 1'b0;
    @(negedge clk);
    check("t5_next", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle();

    // Asynchronous reset while waiting for the painter to finish
    do_reset();
    busy_cycles = 8;
    send(0, 77, 88, 20);
    repeat (3) @(posedge clk);
    #3 sb_en = 0;
    rst_n = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 0);
    check("t6_valid", 32'(pv), 0);
    check("t6_h", 32'(ph), 0);
    check("t6_v", 32'(pvv), 0);
    check("t6_r", 32'(pr), 0);
    check("t6_gid", 32'(gid), 0);
    check("t6_ready", 32'(req_ready), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    sb_init();
    grant_log.delete();
    sb_en = 1;
    for (int i = 0; i < N; i++) job[i] = mkjob(i, i, 5);
    req_valid = 4'b1111;
    @(negedge clk);
    check("t6_prio", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle();

    // Random traffic against the reference model
    do_reset();
    acc = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 99) < 30) begin
          sel = $urandom_range(0, 9);
          job[i] = mkjob($urandom_range(0, 2047), $urandom_range(0, 1023),
                         (sel == 0) ? 0 : (sel < 3) ? $urandom_range(65, 300)
                                                    : $urandom_range(1, 64));
          req_valid[i] = 1'b1;
        end
      end
      hold = ($urandom_range(0, 99) < 10);
      busy_cycles = $urandom_range(1, 6);
      @(negedge clk);
      acc = req_ready & req_valid;
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    hold = 1'b0;
    wait_idle();
    sb_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
